msg_framer: RTL and testbench
=============================

# msg_framer

Transmit-side AXI-Stream message framer, the sending counterpart to the receive-side message-length counter. It accepts a message-length command, passes exactly that many data beats from an upstream source to the downstream AXI-Stream interface through one registered output stage, and asserts `m_tlast` on the final beat. It sits between the payload source and the link transmitter, so every message leaves the block with a correct length and terminator.

## Interface
- `DATA_WIDTH`, 32, width of the data beat
- `NUM_COUNT_BITS`, 16, width of the length and beat counters; the maximum message is 2^NUM_COUNT_BITS-1 beats

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  length command valid
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_length`  in  NUM_COUNT_BITS  beats in the next message
- `s_tdata`  in  DATA_WIDTH  upstream payload
- `s_tvalid`  in  1  upstream beat valid
- `s_tready`  out  1  upstream beat accepted when `s_tvalid && s_tready`
- `m_tdata`  out  DATA_WIDTH  downstream payload (registered)
- `m_tvalid`  out  1  downstream beat valid (registered)
- `m_tlast`  out  1  final beat of the message (registered)
- `m_tready`  in  1  downstream ready
- `beat_count`  out  NUM_COUNT_BITS  input beats accepted in the current or most recent message
- `busy`  out  1  state is not IDLE
- `msg_done`  out  1  one-cycle pulse after the last beat leaves
- `len_err`  out  1  one-cycle pulse after a zero-length command is accepted

## Operation
- States:
  - IDLE: `cmd_ready=1`.
    - Command accepted with `cmd_length!=0`: latch the length, clear `beat_count`, go to SEND.
    - Command accepted with `cmd_length==0`: stay in IDLE and pulse `len_err`.
  - SEND: `s_tready = !m_tvalid || m_tready`.
    - Each input handshake loads the output register with `m_tvalid=1` and `m_tdata=s_tdata`, and increments `beat_count`.
    - When `beat_count+1 == length` (compare at NUM_COUNT_BITS+1 bits, so there is no wrap), the loaded beat has `m_tlast=1` and the next state is DRAIN.
  - DRAIN: `s_tready=0`.
    - When the output handshake `m_tvalid && m_tready && m_tlast` occurs, go to IDLE and pulse `msg_done`.
- Output register:
  - Clears `m_tvalid` and `m_tlast` on an output handshake unless it is reloaded in the same cycle.
  - A simultaneous drain and load is allowed and gives full throughput.
- AXI stability: while `m_tvalid && !m_tready`, `m_tdata`, `m_tlast` and `m_tvalid` hold.
- `cmd_ready` is 0 in SEND and DRAIN; the next command waits until IDLE.
- `beat_count` holds its final value in IDLE until the next non-zero command is accepted.
- `s_tdata` is ignored when `s_tvalid=0`. `m_tready` is ignored when `m_tvalid=0`.
- Length 1: the first beat carries `m_tlast`, and the block goes straight to DRAIN.
- Length 2^N-1: `beat_count` reaches all-ones with no overflow.

## Timing
- Reset:
  - While `rst=1`, `cmd_ready` and `s_tready` are forced to 0.
  - On the clock edge with `rst=1`: state goes to IDLE, and `m_tvalid`, `m_tlast`, `m_tdata`, `beat_count`, `busy`, `msg_done` and `len_err` all go to 0.
  - In the first cycle after `rst` deasserts, `cmd_ready=1`.
- Reset mid-message: the partial frame is discarded and no `m_tlast` is emitted. `m_tvalid` is 0 after the reset edge, even if `m_tready` was low.
- Command latency: a command accepted at edge 0 gives `s_tready` high in the cycle after edge 0, if the output register is free.
- Data latency: an input beat accepted at edge k is on `m_tdata`/`m_tvalid` after edge k, i.e. one cycle.
- Throughput: 1 beat per cycle with `m_tready` held high.
- `msg_done` is high for exactly the one cycle after the edge of the last output handshake. `busy=0` and `cmd_ready=1` in that same cycle.
- Inter-message gap: the minimum number of cycles from the last beat's output handshake to the next message's first `s_tready` is 2 (one for the IDLE command cycle, one for the SEND cycle).
- `len_err` is high for the one cycle after the zero-length command edge.

## Test plan
- **Basic message:** `cmd_length=4`; data 0xA0..0xA3 streamed; `m_tready=1` -> four consecutive output beats with `m_tlast` on 0xA3 only, `beat_count=4`, `msg_done` pulses once, then `cmd_ready=1`.
- **Back-pressure:** `cmd_length=3`; `m_tready` toggles 1,0,0,1,... -> `m_tdata` is stable while stalled, `s_tready=0` whenever `m_tvalid && !m_tready`, and the output order is preserved with `m_tlast` on the 3rd beat.
- **Boundary lengths:** `cmd_length=1` -> a single beat with `m_tlast=1`. `cmd_length=0` -> `len_err` pulses for 1 cycle, no `s_tready`, and the block stays in IDLE.
- **Maximum length:** `NUM_COUNT_BITS=4`, `cmd_length=15` -> 15 beats, `m_tlast` on the 15th, `beat_count=15` with no wrap.
- **Reset mid-message:** `cmd_length=8`; assert `rst` after 3 beats with `m_tready=0` -> `m_tvalid=0` and `beat_count=0` after the edge, no `m_tlast` emitted. A new `cmd_length=2` then completes normally.
- **Back-to-back commands:** `cmd_valid` held high with lengths 2 then 3 -> the second command is accepted in the `msg_done` cycle, and the output shows 2+3 beats with two `m_tlast` assertions.

Source files
------------

// File: rtl/msg_framer.sv
// msg_framer: transmit-side AXI-Stream framer. Takes a beat-count command,
// forwards exactly that many upstream beats through one registered output
// stage and marks the final beat with m_tlast.
module msg_framer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_COUNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [NUM_COUNT_BITS-1:0] cmd_length,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [NUM_COUNT_BITS-1:0] beat_count,
  output logic                      busy,
  output logic                      msg_done,
  output logic                      len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q;
  logic [NUM_COUNT_BITS-1:0] length_q;
  logic [NUM_COUNT_BITS-1:0] beat_count_q;
  logic [DATA_WIDTH-1:0]     m_tdata_q;
  logic                      m_tvalid_q;
  logic                      m_tlast_q;
  logic                      msg_done_q;
  logic                      len_err_q;

  logic                      cmd_fire;
  logic                      in_fire;
  logic                      out_fire;
  logic                      last_beat;
  logic [NUM_COUNT_BITS:0]   count_inc;

  // Handshake qualifiers and the widened last-beat compare (no wrap at all-ones).
  always_comb begin
    cmd_ready = !rst && (state_q == IDLE);
    s_tready  = !rst && (state_q == SEND) && (!m_tvalid_q || m_tready);
    cmd_fire  = cmd_valid && cmd_ready;
    in_fire   = s_tvalid && s_tready;
    out_fire  = m_tvalid_q && m_tready;
    count_inc = {1'b0, beat_count_q} + {{NUM_COUNT_BITS{1'b0}}, 1'b1};
    last_beat = (count_inc == {1'b0, length_q});
  end

  // Control FSM, beat counter and output register in one sequential block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      length_q     <= '0;
      beat_count_q <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      msg_done_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      msg_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      // Drain first; a same-cycle load below overrides the clear.
      if (out_fire) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_length == '0) begin
              len_err_q <= 1'b1;
            end else begin
              length_q     <= cmd_length;
              beat_count_q <= '0;
              state_q      <= SEND;
            end
          end
        end
        SEND: begin
          if (in_fire) begin
            m_tvalid_q   <= 1'b1;
            m_tdata_q    <= s_tdata;
            m_tlast_q    <= last_beat;
            beat_count_q <= count_inc[NUM_COUNT_BITS-1:0];
            if (last_beat) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire && m_tlast_q) begin
            state_q    <= IDLE;
            msg_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign beat_count = beat_count_q;
  assign busy       = (state_q != IDLE);
  assign msg_done   = msg_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_msg_framer.sv
// Self-checking bench for msg_framer. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so every sample reflects the values that
// the next rising edge will act on.
module tb_msg_framer;

  localparam int DW  = 32;
  localparam int NCB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [NCB-1:0] cmd_length = '0;
  logic [DW-1:0]  s_tdata = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready = 1'b0;
  logic [NCB-1:0] beat_count;
  logic           busy;
  logic           msg_done;
  logic           len_err;

  msg_framer #(.DATA_WIDTH(DW), .NUM_COUNT_BITS(NCB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .beat_count(beat_count), .busy(busy), .msg_done(msg_done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus configuration and observation record of one stream() run.
  int            cmd_lens[$];
  bit            sv_always;
  bit            fixed_data;
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  bit            cmd_in_done[$];
  int done_pulses, stall_viol, sready_viol, cmd_lat;
  int first_acc_cyc, first_out_cyc, last_out_cyc, tl_cyc, sr2_cyc;
  bit timed_out;

  // Reference: output stream must equal accepted input stream, with tlast
  // exactly on the final beat of each commanded length.
  function automatic int bad_beats();
    int bad = 0;
    int total = 0;
    int k = 0;
    foreach (cmd_lens[i]) total += cmd_lens[i];
    if (obs_data.size() != total || acc_q.size() != total) bad++;
    for (int i = 0; i < cmd_lens.size(); i++) begin
      for (int j = 0; j < cmd_lens[i]; j++) begin
        if (k < obs_data.size() && k < acc_q.size()) begin
          if (obs_data[k] !== acc_q[k] || obs_last[k] != (j == cmd_lens[i] - 1)) bad++;
        end
        k++;
      end
    end
    return bad;
  endfunction

  // Drives all commands in cmd_lens (cmd_valid held while any remain) and
  // payload, recording what the DUT does. mode: 0 ready=1, 1 ready 1,0,0,1, 2 random.
  task automatic stream(input int mode);
    int  idx = 0;
    int  cyc = 0;
    int  cmd_cyc = -1;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    acc_q.delete(); obs_data.delete(); obs_last.delete(); cmd_in_done.delete();
    done_pulses = 0; stall_viol = 0; sready_viol = 0; cmd_lat = -1;
    first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; tl_cyc = -1; sr2_cyc = -1;
    while (done_pulses < cmd_lens.size() && cyc < 400) begin
      @(negedge clk);
      cmd_valid  = (idx < cmd_lens.size());
      cmd_length = cmd_valid ? NCB'(cmd_lens[idx]) : '0;
      s_tvalid   = sv_always ? 1'b1 : ($urandom_range(0, 9) < 8);
      s_tdata    = fixed_data ? (32'hA0 + DW'(acc_q.size())) : $urandom;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
        stall_viol++;
      if (m_tvalid && !m_tready && s_tready) sready_viol++;
      if (msg_done) done_pulses++;
      if (cmd_valid && cmd_ready) begin
        cmd_in_done.push_back(msg_done);
        if (idx == 0) cmd_cyc = cyc;
        idx++;
      end
      if (s_tready && tl_cyc >= 0 && sr2_cyc < 0 && cyc > tl_cyc) sr2_cyc = cyc;
      if (s_tvalid && s_tready) begin
        acc_q.push_back(s_tdata);
        if (first_acc_cyc < 0) begin
          first_acc_cyc = cyc;
          cmd_lat = cyc - cmd_cyc;
        end
      end
      if (m_tvalid && m_tready) begin
        obs_data.push_back(m_tdata);
        obs_last.push_back(m_tlast);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (m_tlast && tl_cyc < 0) tl_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      cyc++;
    end
    timed_out = (done_pulses < cmd_lens.size());
    // One idle cycle after the last pulse: catches a stretched msg_done.
    @(negedge clk);
    cmd_valid = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    if (msg_done) done_pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_length = 4'd3; s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || s_tready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: cmd_ready=%b s_tready=%b want 0 0", cmd_ready, s_tready);
    end
    checks++;
    if ({m_tvalid, m_tlast, busy, msg_done, len_err} !== 5'b0 || m_tdata !== '0 || beat_count !== '0) begin
      failures++;
      $display("FAIL reset_state: v=%b l=%b busy=%b done=%b err=%b data=%h cnt=%0d want all 0",
               m_tvalid, m_tlast, busy, msg_done, len_err, m_tdata, beat_count);
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    cmd_lens = '{4}; sv_always = 1'b1; fixed_data = 1'b1;
    stream(0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout: done=%0d want 1", done_pulses); end
    checks++;
    if (bad_beats() !== 0) begin failures++; $display("FAIL basic_frame: bad=%0d want 0", bad_beats()); end
    checks++;
    if (obs_data.size() != 4 || obs_data[0] !== 32'hA0 || obs_data[3] !== 32'hA3) begin
      failures++; $display("FAIL basic_data: n=%0d want 4 beats A0..A3", obs_data.size());
    end
    checks++;
    if (cmd_lat !== 1) begin failures++; $display("FAIL basic_cmd_latency: %0d want 1", cmd_lat); end
    checks++;
    if (first_out_cyc - first_acc_cyc !== 1) begin
      failures++; $display("FAIL basic_data_latency: %0d want 1", first_out_cyc - first_acc_cyc);
    end
    checks++;
    if (last_out_cyc - first_out_cyc !== 3) begin
      failures++; $display("FAIL basic_throughput: span=%0d want 3", last_out_cyc - first_out_cyc);
    end
    checks++;
    if (done_pulses !== 1) begin failures++; $display("FAIL basic_done_pulses: %0d want 1", done_pulses); end
    checks++;
    if (beat_count !== 4'd4 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_end: cnt=%0d rdy=%b busy=%b want 4 1 0", beat_count, cmd_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    cmd_lens = '{3}; sv_always = 1'b0; fixed_data = 1'b0;
    stream(1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL bp_timeout: done=%0d want 1", done_pulses); end
    checks++;
    if (bad_beats() !== 0) begin failures++; $display("FAIL bp_frame: bad=%0d want 0", bad_beats()); end
    checks++;
    if (stall_viol !== 0) begin failures++; $display("FAIL bp_stable: violations=%0d want 0", stall_viol); end
    checks++;
    if (sready_viol !== 0) begin failures++; $display("FAIL bp_sready: violations=%0d want 0", sready_viol); end
    checks++;
    if (beat_count !== 4'd3) begin failures++; $display("FAIL bp_count: %0d want 3", beat_count); end
  endtask

  task automatic test_boundary();
    int sr_seen = 0;
    cmd_lens = '{1}; sv_always = 1'b1; fixed_data = 1'b0;
    stream(2);
    checks++;
    if (timed_out || bad_beats() !== 0 || obs_data.size() != 1) begin
      failures++; $display("FAIL len1_frame: beats=%0d bad=%0d timeout=%b want 1 0 0",
                           obs_data.size(), bad_beats(), timed_out);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_length = '0;
    #1;
    checks++;
    if (len_err !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL len0_pre: len_err=%b cmd_ready=%b want 0 1", len_err, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; s_tvalid = 1'b1;
    #1;
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL len0_pulse: len_err=%b busy=%b rdy=%b want 1 0 1", len_err, busy, cmd_ready);
    end
    if (s_tready) sr_seen++;
    @(negedge clk);
    #1;
    checks++;
    if (len_err !== 1'b0) begin failures++; $display("FAIL len0_width: len_err=%b want 0", len_err); end
    for (int i = 0; i < 3; i++) begin
      if (s_tready) sr_seen++;
      @(negedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    checks++;
    if (sr_seen !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL len0_idle: s_tready_cycles=%0d busy=%b want 0 0", sr_seen, busy);
    end
  endtask

  task automatic test_max_length();
    cmd_lens = '{15}; sv_always = 1'b0; fixed_data = 1'b0;
    stream(2);
    checks++;
    if (timed_out || bad_beats() !== 0) begin
      failures++; $display("FAIL max_frame: bad=%0d timeout=%b want 0 0", bad_beats(), timed_out);
    end
    checks++;
    if (beat_count !== 4'd15) begin failures++; $display("FAIL max_count: %0d want 15", beat_count); end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int budget = 0;
    bit tlast_seen = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_length = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
    while (acc < 3 && budget < 50) begin
      s_tdata = $urandom;
      #1;
      if (s_tvalid && s_tready) acc++;
      if (m_tvalid && m_tlast) tlast_seen = 1'b1;
      budget++;
      @(negedge clk);
    end
    s_tvalid = 1'b0; m_tready = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (acc !== 3 || m_tvalid !== 1'b1 || s_tready !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_pre: acc=%0d v=%b s_rdy=%b c_rdy=%b want 3 1 0 0",
                           acc, m_tvalid, s_tready, cmd_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || beat_count !== '0 || busy !== 1'b0 || tlast_seen) begin
      failures++; $display("FAIL rstmid_post: v=%b l=%b cnt=%0d busy=%b seen_last=%b want 0 0 0 0 0",
                           m_tvalid, m_tlast, beat_count, busy, tlast_seen);
    end
    rst = 1'b0;
    cmd_lens = '{2}; sv_always = 1'b0; fixed_data = 1'b0;
    stream(2);
    checks++;
    if (timed_out || bad_beats() !== 0 || beat_count !== 4'd2 || done_pulses !== 1) begin
      failures++; $display("FAIL rstmid_recover: bad=%0d cnt=%0d done=%0d timeout=%b want 0 2 1 0",
                           bad_beats(), beat_count, done_pulses, timed_out);
    end
  endtask

  task automatic test_back_to_back();
    cmd_lens = '{2, 3}; sv_always = 1'b1; fixed_data = 1'b0;
    stream(0);
    checks++;
    if (timed_out || bad_beats() !== 0) begin
      failures++; $display("FAIL b2b_frame: bad=%0d timeout=%b want 0 0", bad_beats(), timed_out);
    end
    checks++;
    if (cmd_in_done.size() != 2 || !cmd_in_done[1]) begin
      failures++; $display("FAIL b2b_accept: cmds=%0d want 2 with second in msg_done cycle", cmd_in_done.size());
    end
    checks++;
    if (sr2_cyc - tl_cyc !== 2) begin failures++; $display("FAIL b2b_gap: %0d want 2", sr2_cyc - tl_cyc); end
    checks++;
    if (done_pulses !== 2 || beat_count !== 4'd3) begin
      failures++; $display("FAIL b2b_end: done=%0d cnt=%0d want 2 3", done_pulses, beat_count);
    end
  endtask

  task automatic test_random();
    int n;
    n = $urandom_range(2, 4);
    cmd_lens.delete();
    for (int i = 0; i < n; i++) cmd_lens.push_back($urandom_range(1, 15));
    sv_always = 1'b0; fixed_data = 1'b0;
    stream(2);
    checks++;
    if (timed_out || bad_beats() !== 0) begin
      failures++; $display("FAIL rand_frame: bad=%0d timeout=%b want 0 0", bad_beats(), timed_out);
    end
    checks++;
    if (stall_viol !== 0 || sready_viol !== 0) begin
      failures++; $display("FAIL rand_axi: stall=%0d sready=%0d want 0 0", stall_viol, sready_viol);
    end
    checks++;
    if (done_pulses !== n || beat_count !== NCB'(cmd_lens[n-1])) begin
      failures++; $display("FAIL rand_end: done=%0d cnt=%0d want %0d %0d",
                           done_pulses, beat_count, n, cmd_lens[n-1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_max_length();
    test_reset_mid();
    test_back_to_back();
    for (int r = 0; r < 4; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
